// File: rtl/sram_arb_pkg.sv
// ============================================================================
//  Module : sram_arb_pkg
//  Purpose: Shared types and default sizes for the two-port SRAM arbiter.
//           Holds the controller state encoding, the default field widths
//           and the idle (all-ones, nothing written) byte write-enable value.
//  Ports  : none (package)
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sram_arb_pkg;

  // Default geometry of the shared SRAM macro and burst length field.
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STRB_W = DEF_DATA_W / 8;
  localparam int DEF_LEN_W  = 4;

  // Active-low byte write enables: all ones means no byte is written.
  localparam logic [DEF_STRB_W-1:0] WEB_IDLE = '1;

  // Controller states. RD_TAIL is the extra cycle that returns the data
  // of the final read address, since the SRAM answers one cycle late.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD      = 2'd1,
    ST_RD_TAIL = 2'd2,
    ST_WR      = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
//  Module : rr_arbiter2
//  Purpose: Two-way round-robin pick. A lone requester wins outright; on a
//           tie the port that did not win last time is chosen. The
//           last-grant register only advances when the pick is consumed.
//  Ports  : clk, rst       clock, asynchronous active-high reset
//           req[1:0]       request vector, bit i = port i
//           en             pick is consumed this cycle (update history)
//           grant[1:0]     one-hot grant (zero when nobody requests)
//           grant_idx      index of the granted port
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Reset value 1 makes port 0 the winner of the very first tie.
  logic last_grant;

  always_comb begin
    grant_idx = 1'b0;
    grant     = 2'b00;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
    if (req != 2'b00) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (en && (req != 2'b00)) begin
      last_grant <= grant_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
//  Module : sram_port_arbiter
//  Purpose: Shares one synchronous SRAM macro between two burst requesters
//           (e.g. instruction fetch on port 0, data access on port 1).
//           Round-robin arbitration; a granted burst owns the SRAM until its
//           last beat completes.
//  Ports  : clk, rst                     clock, async active-high reset
//           req_valid/we/addr/len        per-port burst request
//           req_ready                    1-cycle acceptance pulse
//           wdata/wstrb/wvalid, wready   per-port write beat channel
//           rdata, rvalid, rlast         read return (rdata shared)
//           done                         end-of-burst pulse per port
//           sram_cs/oe/web/a/di, sram_do SRAM macro interface
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STRB_W = DEF_STRB_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*LEN_W-1:0]    req_len,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   wdata,
  input  logic [2*STRB_W-1:0]   wstrb,
  input  logic [1:0]            wvalid,
  output logic [1:0]            wready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rvalid,
  output logic [1:0]            rlast,
  output logic [1:0]            done,
  output logic                  sram_cs,
  output logic                  sram_oe,
  output logic [STRB_W-1:0]     sram_web,
  output logic [ADDR_W-1:0]     sram_a,
  output logic [DATA_W-1:0]     sram_di,
  input  logic [DATA_W-1:0]     sram_do
);

  localparam logic [STRB_W-1:0] WEB_OFF = {STRB_W{WEB_IDLE[0]}};

  state_t              state, state_nxt;
  logic                port, port_nxt;
  logic [ADDR_W-1:0]   base, base_nxt;
  logic [LEN_W-1:0]    len, len_nxt;
  logic [LEN_W-1:0]    cnt, cnt_nxt;

  logic                accept;
  logic [1:0]          grant;
  logic                grant_idx;
  logic [1:0]          port_oh;
  logic [ADDR_W-1:0]   beat_addr;
  logic                last_beat;

  // Requests are only looked at in IDLE, and never while reset is held,
  // so req_ready stays low during reset even with requests pending.
  assign accept = (state == ST_IDLE) && (req_valid != 2'b00) && !rst;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign port_oh   = port ? 2'b10 : 2'b01;
  // Word address wraps naturally at 2^ADDR_W.
  assign beat_addr = base + ADDR_W'(cnt);
  assign last_beat = (cnt == len);
  assign rdata     = sram_do;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      port  <= 1'b0;
      base  <= '0;
      len   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      port  <= port_nxt;
      base  <= base_nxt;
      len   <= len_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    port_nxt  = port;
    base_nxt  = base;
    len_nxt   = len;
    cnt_nxt   = cnt;

    req_ready = 2'b00;
    wready    = 2'b00;
    rvalid    = 2'b00;
    rlast     = 2'b00;
    done      = 2'b00;
    sram_cs   = 1'b0;
    sram_oe   = 1'b0;
    sram_web  = WEB_OFF;
    sram_a    = '0;
    sram_di   = '0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          req_ready = grant;
          port_nxt  = grant_idx;
          base_nxt  = req_addr[grant_idx*ADDR_W +: ADDR_W];
          len_nxt   = req_len[grant_idx*LEN_W +: LEN_W];
          cnt_nxt   = '0;
          state_nxt = req_we[grant_idx] ? ST_WR : ST_RD;
        end
      end

      ST_RD: begin
        sram_cs = 1'b1;
        sram_oe = 1'b1;
        sram_a  = beat_addr;
        // Data for the previous address appears now; the first address
        // (cnt == 0) has nothing to return yet.
        if (cnt != '0) begin
          rvalid = port_oh;
        end
        if (last_beat) begin
          state_nxt = ST_RD_TAIL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      ST_RD_TAIL: begin
        sram_oe   = 1'b1;
        rvalid    = port_oh;
        rlast     = port_oh;
        done      = port_oh;
        state_nxt = ST_IDLE;
      end

      ST_WR: begin
        if (wvalid[port]) begin
          wready   = port_oh;
          sram_cs  = 1'b1;
          sram_web = ~wstrb[port*STRB_W +: STRB_W];
          sram_a   = beat_addr;
          sram_di  = wdata[port*DATA_W +: DATA_W];
          if (last_beat) begin
            done      = port_oh;
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
